// File: rtl/music_pkg.sv
// Shared types and defaults for the note/envelope sequencer.
package music_pkg;

    localparam int unsigned TONE_W_DEF = 16;
    localparam int unsigned AMP_W_DEF  = 16;

    localparam logic [TONE_W_DEF-1:0] TONE_REST = '0;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_e;

endpackage

// File: rtl/env_tick_gen.sv
// Free-running prescaler: pulses tick once every TICK_DIV clocks.
module env_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/note_envelope_seq.sv
// Turns the beat index into a sustained note: fetches the tone from the synchronous
// music ROM, detects note changes and shapes amplitude with an attack/sustain/release envelope.
module note_envelope_seq
    import music_pkg::*;
#(
    parameter int unsigned         TONE_W   = TONE_W_DEF,
    parameter int unsigned         AMP_W    = AMP_W_DEF,
    parameter logic [AMP_W-1:0]    AMP_MAX  = 'h7FFF,
    parameter logic [AMP_W-1:0]    ATK_STEP = 'h0400,
    parameter logic [AMP_W-1:0]    REL_STEP = 'h0200,
    parameter int unsigned         TICK_DIV = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_pause,
    input  logic [11:0]       ibeat,
    output logic [11:0]       rom_addr,
    input  logic [TONE_W-1:0] rom_tone,
    output logic [TONE_W-1:0] freq_out,
    output logic [AMP_W-1:0]  amp_out,
    output logic              note_active
);

    env_state_e state_q;
    logic       primed_q, chg1_q, chg2_q, play_q;
    logic       tick;

    env_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic [AMP_W:0]   atk_sum;
    logic             atk_sat;
    logic [AMP_W-1:0] rel_next;
    logic             tone_ev, is_rest, retrig, rest_rel, play_fall, play_rise, sounding;

    assign atk_sum  = {1'b0, amp_out} + {1'b0, ATK_STEP};
    assign atk_sat  = (atk_sum >= {1'b0, AMP_MAX});
    assign rel_next = (amp_out > REL_STEP) ? (amp_out - REL_STEP) : '0;

    assign sounding  = (state_q == ATTACK) || (state_q == SUSTAIN);
    assign tone_ev   = chg2_q && play_pause;
    assign is_rest   = (rom_tone == TONE_W'(TONE_REST));
    assign retrig    = tone_ev && !is_rest && (rom_tone != freq_out);
    assign rest_rel  = tone_ev && is_rest && sounding;
    assign play_fall = play_q && !play_pause && sounding;
    assign play_rise = !play_q && play_pause && (freq_out != '0) && !sounding;

    assign note_active = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            primed_q <= 1'b0;
            chg1_q   <= 1'b0;
            chg2_q   <= 1'b0;
            play_q   <= 1'b0;
            freq_out <= '0;
            amp_out  <= '0;
            state_q  <= IDLE;
        end else begin
            rom_addr <= ibeat;
            // First edge after reset forces a fetch so the current beat is replayed.
            chg1_q   <= (ibeat != rom_addr) || !primed_q;
            primed_q <= 1'b1;
            chg2_q   <= chg1_q;
            play_q   <= play_pause;

            if (retrig) begin
                freq_out <= rom_tone;
                amp_out  <= '0;
                state_q  <= ATTACK;
            end else if (rest_rel || play_fall) begin
                state_q <= RELEASE;
            end else if (play_rise) begin
                state_q <= ATTACK;
            end else if (tick) begin
                case (state_q)
                    ATTACK: begin
                        if (atk_sat) begin
                            amp_out <= AMP_MAX;
                            state_q <= SUSTAIN;
                        end else begin
                            amp_out <= atk_sum[AMP_W-1:0];
                        end
                    end
                    RELEASE: begin
                        amp_out <= rel_next;
                        if (rel_next == '0) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_envelope_seq.sv
// Directed bench for note_envelope_seq with a synchronous ROM model and TICK_DIV=4.
module tb_note_envelope_seq;
    import music_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play_pause = 1'b1;
    logic [11:0] ibeat = '0;
    logic [11:0] rom_addr;
    logic [15:0] rom_tone;
    logic [15:0] freq_out;
    logic [15:0] amp_out;
    logic        note_active;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;   // non-reset edges since last reset edge; tick lands where ncyc % 4 == 0

    logic [15:0] rom [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) rom_tone <= rom[rom_addr];

    note_envelope_seq #(
        .TONE_W   (16),
        .AMP_W    (16),
        .AMP_MAX  (16'h7FFF),
        .ATK_STEP (16'h2000),
        .REL_STEP (16'h1000),
        .TICK_DIV (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play_pause  (play_pause),
        .ibeat       (ibeat),
        .rom_addr    (rom_addr),
        .rom_tone    (rom_tone),
        .freq_out    (freq_out),
        .amp_out     (amp_out),
        .note_active (note_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_env(input string tag, input logic [15:0] f, input logic [15:0] a,
                              input env_state_e s);
        check({tag, ".freq"},   32'(freq_out),     32'(f));
        check({tag, ".amp"},    32'(amp_out),      32'(a));
        check({tag, ".state"},  32'(dut.state_q),  32'(s));
        check({tag, ".active"}, 32'(note_active),  32'(s != IDLE));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) ncyc = 0;
        else ncyc++;
        #1;
    endtask

    task automatic to_tick();
        step();
        while (ncyc % 4 != 0) step();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 16'd0;
        rom[1]  = 16'd262;
        rom[3]  = 16'd330;
        rom[4]  = 16'd330;
        rom[48] = 16'd392;
        rom[63] = 16'd330;

        // Reset state
        reset = 1'b1;
        step();
        step();
        check("reset.rom_addr", 32'(rom_addr), 32'd0);
        expect_env("reset", 16'd0, 16'h0000, IDLE);
        reset = 1'b0;
        step(); step(); step();
        expect_env("idle_rest", 16'd0, 16'h0000, IDLE);

        // Note on: 2-clock latency, then attack ramp to sustain
        ibeat = 12'd1;
        step();
        check("fetch.rom_addr", 32'(rom_addr), 32'd1);
        expect_env("lat_e1", 16'd0, 16'h0000, IDLE);
        step();
        expect_env("lat_e2", 16'd0, 16'h0000, IDLE);
        step();
        expect_env("note_on", 16'd262, 16'h0000, ATTACK);
        to_tick(); expect_env("atk1", 16'd262, 16'h2000, ATTACK);
        to_tick(); expect_env("atk2", 16'd262, 16'h4000, ATTACK);
        to_tick(); expect_env("atk3", 16'd262, 16'h6000, ATTACK);
        to_tick(); expect_env("atk4", 16'd262, 16'h7FFF, SUSTAIN);

        // Rest: release with held frequency down to idle
        ibeat = 12'd2;
        step(); step();
        expect_env("rest_lat", 16'd262, 16'h7FFF, SUSTAIN);
        step();
        expect_env("rest_on", 16'd262, 16'h7FFF, RELEASE);
        for (int k = 1; k <= 7; k++) begin
            logic [15:0] e;
            e = 16'h7FFF - 16'(k) * 16'h1000;
            to_tick();
            expect_env("rel", 16'd262, e, RELEASE);
        end
        to_tick();
        expect_env("rel_end", 16'd262, 16'h0000, IDLE);

        // Tied note: ROM[3]==ROM[4] must not retrigger
        ibeat = 12'd3;
        step(); step(); step();
        expect_env("n330_on", 16'd330, 16'h0000, ATTACK);
        to_tick(); expect_env("n330_a1", 16'd330, 16'h2000, ATTACK);
        ibeat = 12'd4;
        step(); step(); step();
        expect_env("tied", 16'd330, 16'h2000, ATTACK);
        to_tick(); expect_env("tied_a2", 16'd330, 16'h4000, ATTACK);
        to_tick(); expect_env("tied_a3", 16'd330, 16'h6000, ATTACK);
        to_tick(); expect_env("tied_sus", 16'd330, 16'h7FFF, SUSTAIN);

        // Pause releases, resume re-attacks from current amplitude
        play_pause = 1'b0;
        step();
        expect_env("pause", 16'd330, 16'h7FFF, RELEASE);
        to_tick(); to_tick(); to_tick();
        expect_env("pause_r3", 16'd330, 16'h4FFF, RELEASE);
        play_pause = 1'b1;
        step();
        expect_env("resume", 16'd330, 16'h4FFF, ATTACK);
        to_tick(); expect_env("resume_a1", 16'd330, 16'h6FFF, ATTACK);
        to_tick(); expect_env("resume_a2", 16'd330, 16'h7FFF, SUSTAIN);

        // Back-to-back 63 then 48 (loop jump); retrigger lands on a tick edge and wins
        ibeat = 12'd63;
        step();
        ibeat = 12'd48;
        step();
        check("jump.rom_addr", 32'(rom_addr), 32'd48);
        step();
        expect_env("jump_63", 16'd330, 16'h7FFF, SUSTAIN);
        step();
        expect_env("jump_48", 16'd392, 16'h0000, ATTACK);
        to_tick(); expect_env("jump_a1", 16'd392, 16'h2000, ATTACK);
        to_tick(); expect_env("jump_a2", 16'd392, 16'h4000, ATTACK);

        // Mid-note reset, then refetch of the current beat
        reset = 1'b1;
        step();
        check("mid_reset.rom_addr", 32'(rom_addr), 32'd0);
        expect_env("mid_reset", 16'd0, 16'h0000, IDLE);
        reset = 1'b0;
        step();
        check("refetch.rom_addr", 32'(rom_addr), 32'd48);
        expect_env("refetch_e1", 16'd0, 16'h0000, IDLE);
        step(); step();
        expect_env("refetch_on", 16'd392, 16'h0000, ATTACK);
        to_tick(); expect_env("refetch_a1", 16'd392, 16'h2000, ATTACK);

        // Tone event ignored while paused; the coincident tick still applies
        play_pause = 1'b0;
        step();
        expect_env("pause2", 16'd392, 16'h2000, RELEASE);
        ibeat = 12'd3;
        step(); step(); step();
        expect_env("paused_ev", 16'd392, 16'h1000, RELEASE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
